sata_dma_cmd_issuer: RTL and testbench

Command sequencer directly upstream of the SATA host controller's host/shadow-register interface. Accepts one 48-bit-LBA DMA read or write request per handshake and writes the ATA shadow registers. It then holds the DMA request high, waits for the interrupt-pending flag, reads back the status register and reports completion or error. Runs in the controller's link/transport clock domain (the controller clock output).

---
 rtl/sata_cmd_pkg.sv | 40 ++++
 rtl/sata_cmd_timeout_cnt.sv | 17 +
 rtl/sata_dma_cmd_issuer.sv | 101 ++++++++++
 tb/tb_sata_dma_cmd_issuer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sata_cmd_pkg.sv
// sata_cmd_pkg: shadow register map, ATA opcodes, status bits and issuer FSM encoding.
package sata_cmd_pkg;
  localparam logic [4:0] REG_FEATURES = 5'd1;
  localparam logic [4:0] REG_COUNT = 5'd2;
  localparam logic [4:0] REG_LBA_LOW = 5'd3;
  localparam logic [4:0] REG_LBA_MID = 5'd4;
  localparam logic [4:0] REG_LBA_HIGH = 5'd5;
  localparam logic [4:0] REG_DEVICE = 5'd6;
  localparam logic [4:0] REG_COMMAND = 5'd7;
  localparam logic [7:0] ATA_READ_DMA_EXT = 8'h25;
  localparam logic [7:0] ATA_WRITE_DMA_EXT = 8'h35;
  localparam logic [7:0] DEVICE_LBA = 8'h40;
  localparam int STS_ERR = 0;
  localparam int STS_DF = 5;
  localparam int STS_BSY = 7;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR_REGS = 3'd1;
  localparam logic [2:0] S_WAIT_IPF = 3'd2;
  localparam logic [2:0] S_RD_STATUS = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  typedef struct packed {
    logic write;
    logic [47:0] lba;
    logic [15:0] count;
  } cmd_t;
  // 48-bit LBA goes out as previous/current byte pairs per shadow register
  function automatic logic [15:0] shadow_data(input logic [2:0] idx, input cmd_t c);
    case (idx)
      3'd0: return 16'h0000;
      3'd1: return c.count;
      3'd2: return {c.lba[31:24], c.lba[7:0]};
      3'd3: return {c.lba[39:32], c.lba[15:8]};
      3'd4: return {c.lba[47:40], c.lba[23:16]};
      3'd5: return {8'h00, DEVICE_LBA};
      3'd6: return {8'h00, c.write ? ATA_WRITE_DMA_EXT : ATA_READ_DMA_EXT};
      default: return 16'h0000;
    endcase
  endfunction
endpackage

// File: rtl/sata_cmd_timeout_cnt.sv
// sata_cmd_timeout_cnt: cycle counter that flags the last allowed cycle of a wait.
module sata_cmd_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16777216
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (reset || clear) cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  assign expired = enable && (cnt == W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/sata_dma_cmd_issuer.sv
// sata_dma_cmd_issuer: issues one 48-bit DMA EXT command through the shadow registers and reports completion.
module sata_dma_cmd_issuer
  import sata_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16777216,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [47:0] cmd_lba,
  input  logic [15:0] cmd_count,
  input  logic        linkup,
  input  logic        ipf,
  input  logic        r_err,
  input  logic        illegal_state,
  output logic        host_write_en,
  output logic        host_read_en,
  output logic [4:0]  host_addr_reg,
  output logic [31:0] host_data_out,
  input  logic [31:0] host_data_in,
  output logic        dma_rqst,
  output logic        ce,
  output logic        done_valid,
  output logic        done_error,
  output logic        done_timeout,
  output logic [7:0]  done_status
);
  logic [2:0] state, idx;
  cmd_t cmd;
  logic [7:0] status_q;
  logic abort_q, tmo_q, abort, expired, unused_data;
  assign unused_data = ^host_data_in[31:8];
  // a link drop can only be seen as low here, since accept requires linkup high
  assign abort = (state != S_IDLE) && (state != S_DONE) && (r_err || illegal_state || !linkup);
  assign cmd_ready = (state == S_IDLE) && linkup && !reset;
  sata_cmd_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk),
    .reset(reset),
    .clear(state != S_WAIT_IPF),
    .enable(state == S_WAIT_IPF),
    .expired(expired)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      idx <= '0;
      cmd <= '0;
      status_q <= '0;
      abort_q <= 1'b0;
      tmo_q <= 1'b0;
    end else if (abort) begin
      state <= S_DONE;
      status_q <= '0;
      abort_q <= 1'b1;
      tmo_q <= 1'b0;
    end else case (state)
      S_IDLE: if (cmd_valid && cmd_ready) begin
        cmd <= '{write: cmd_write, lba: cmd_lba, count: cmd_count};
        idx <= '0;
        status_q <= '0;
        abort_q <= 1'b0;
        tmo_q <= 1'b0;
        state <= S_WR_REGS;
      end
      S_WR_REGS: begin
        idx <= idx + 3'd1;
        if (idx == 3'd6) state <= S_WAIT_IPF;
      end
      S_WAIT_IPF: if (ipf) state <= S_RD_STATUS;
        else if (expired) begin
          tmo_q <= 1'b1;
          status_q <= '0;
          state <= S_DONE;
        end
      S_RD_STATUS: begin
        idx <= '0;
        state <= S_RD_WAIT;
      end
      S_RD_WAIT: begin
        idx <= idx + 3'd1;
        if (idx == 3'(READ_LATENCY - 1)) begin
          status_q <= host_data_in[7:0];
          state <= S_DONE;
        end
      end
      default: state <= S_IDLE;
    endcase
  assign host_write_en = state == S_WR_REGS;
  assign host_read_en = state == S_RD_STATUS;
  assign host_addr_reg = host_write_en ? REG_FEATURES + {2'b00, idx} : host_read_en ? REG_COMMAND : 5'd0;
  assign host_data_out = host_write_en ? {16'h0000, shadow_data(idx, cmd)} : 32'h0;
  assign dma_rqst = state != S_IDLE;
  assign ce = state != S_IDLE;
  assign done_valid = state == S_DONE;
  assign done_timeout = done_valid && tmo_q;
  assign done_error = done_valid && (abort_q || tmo_q || status_q[STS_ERR] || status_q[STS_DF] || status_q[STS_BSY]);
  assign done_status = done_valid ? status_q : 8'h00;
endmodule

// File: tb/tb_sata_dma_cmd_issuer.sv
// tb_sata_dma_cmd_issuer: randomized scoreboard bench for the DMA command issuer.
module tb_sata_dma_cmd_issuer;
  localparam int TMO = 24;
  logic clk = 0, reset = 1, cmd_valid = 0, cmd_write = 0, linkup = 1, ipf = 0, r_err = 0, illegal_state = 0;
  logic [47:0] cmd_lba = '0;
  logic [15:0] cmd_count = '0;
  logic [31:0] host_data_in = '0;
  logic cmd_ready, host_write_en, host_read_en, dma_rqst, ce, done_valid, done_error, done_timeout;
  logic [4:0] host_addr_reg;
  logic [31:0] host_data_out;
  logic [7:0] done_status;
  typedef struct packed { logic [4:0] addr; logic [31:0] data; logic [31:0] cyc; } wr_t;
  typedef struct packed { logic err; logic tmo; logic [7:0] st; logic [31:0] cyc; } dn_t;
  wr_t wq[$];
  dn_t dq[$];
  wr_t mw;
  dn_t md;
  int checks = 0, passed = 0, cyc = 0, a_start = 1, a_end = 0;
  logic [7:0] status_byte = '0;

  sata_dma_cmd_issuer #(.TIMEOUT_CYCLES(TMO), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_lba(cmd_lba), .cmd_count(cmd_count), .linkup(linkup), .ipf(ipf), .r_err(r_err),
    .illegal_state(illegal_state), .host_write_en(host_write_en), .host_read_en(host_read_en),
    .host_addr_reg(host_addr_reg), .host_data_out(host_data_out), .host_data_in(host_data_in),
    .dma_rqst(dma_rqst), .ce(ce), .done_valid(done_valid), .done_error(done_error),
    .done_timeout(done_timeout), .done_status(done_status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // device side: status appears one cycle after the read strobe, junk otherwise
  always @(posedge clk) host_data_in <= host_read_en ? {24'($urandom), status_byte} : $urandom;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic recover();
    reset = 1;
    step();
    reset = 0;
    wq.delete();
    dq.delete();
    a_end = cyc - 1;
  endtask

  // shadow register contents in issue order, straight from the ATA 48-bit register layout
  function automatic logic [15:0] reg_val(input int i, input logic w, input logic [47:0] l, input logic [15:0] c);
    logic [15:0] t[7];
    t = '{16'h0000, c, {l[31:24], l[7:0]}, {l[39:32], l[15:8]}, {l[47:40], l[23:16]}, 16'h0040, w ? 16'h0035 : 16'h0025};
    return t[i];
  endfunction

  // modes: 0 ipf, 1 timeout, 2 r_err on write d, 3 illegal_state, 4 link drop, 5 reset, 6 r_err with ipf, 7 r_err in status read
  task automatic run(input int mode, input logic w, input logic [47:0] lba, input logic [15:0] cnt, input int d, input logic [7:0] st);
    int a, e, nw;
    logic ok;
    cmd_valid = 1; cmd_write = w; cmd_lba = lba; cmd_count = cnt; ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
    end
    chk("accept", 80'(ok), 80'(1));
    if (!ok) begin
      cmd_valid = 0;
      recover();
      return;
    end
    step();
    cmd_valid = 0; a = cyc; status_byte = st;
    nw = (mode == 2) ? d + 1 : 7;
    for (int k = 0; k < nw; k++) wq.push_back(wr_t'{5'(k + 1), {16'h0, reg_val(k, w, lba, cnt)}, 32'(a + k)});
    case (mode)
      0: e = a + 10 + d;
      1: e = a + 7 + TMO;
      2: e = a + d + 1;
      7: e = a + 9 + d;
      5: e = a + 7 + d;
      default: e = a + 8 + d;
    endcase
    if (mode != 5) dq.push_back(dn_t'{mode == 0 ? (st & 8'hA1) != 0 : 1'b1, mode == 1, mode == 0 ? st : 8'h00, 32'(e)});
    a_start = a; a_end = e;
    if (mode == 2) begin
      repeat (d) step();
      r_err = 1;
      step();
      r_err = 0;
    end else if (mode != 1) begin
      repeat (7) step();
      cmd_valid = 1; cmd_lba = ~lba; cmd_write = ~w;
      @(negedge clk);
      chk("busy_ready", 80'(cmd_ready), 80'(0));
      repeat (d) step();
      cmd_valid = 0;
      case (mode)
        3: illegal_state = 1;
        4: linkup = 0;
        5: reset = 1;
        6: begin ipf = 1; r_err = 1; end
        default: ipf = 1;
      endcase
      step();
      ipf = 0; illegal_state = 0; linkup = 1; reset = 0; r_err = (mode == 7);
      step();
      r_err = 0;
    end
    while (cyc <= e) step();
    chk("writes_drained", 80'(wq.size()), 80'(0));
    chk("done_drained", 80'(dq.size()), 80'(0));
    if (wq.size() != 0 || dq.size() != 0) recover();
  endtask

  always @(negedge clk) begin
    chk("ce_dma_window", {78'(0), ce, dma_rqst}, {78'(0), {2{cyc >= a_start && cyc <= a_end}}});
    if (host_write_en) begin
      chk("write_expected", 80'(wq.size() != 0), 80'(1));
      if (wq.size() != 0) begin
        mw = wq.pop_front();
        chk("shadow_write", {host_addr_reg, host_data_out, 32'(cyc)}, mw);
      end
    end
    if (host_read_en) chk("status_read", {host_write_en, host_addr_reg}, {1'b0, 5'd7});
    if (done_valid) begin
      chk("done_expected", 80'(dq.size() != 0), 80'(1));
      if (dq.size() != 0) begin
        md = dq.pop_front();
        chk("done", {done_error, done_timeout, done_status, 32'(cyc)}, md);
      end
    end else chk("done_quiet", {done_error, done_timeout, done_status}, 10'h0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int mode, d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {cmd_ready, host_write_en, host_read_en, host_addr_reg, host_data_out, dma_rqst, ce,
        done_valid, done_error, done_timeout, done_status}, 80'(0));
    step();
    reset = 0;
    @(negedge clk);
    chk("ready_after_reset", 80'(cmd_ready), 80'(1));
    step();
    run(0, 0, 48'h0000_1234_5678, 16'd8, 20, 8'h50);
    run(0, 1, 48'h0ABC_DEF0_1357, 16'd0, 5, 8'h51);
    run(1, 0, 48'h0000_0000_0001, 16'd1, 0, 8'h00);
    run(2, 1, 48'hFEDC_BA98_7654, 16'd3, 2, 8'h00);
    linkup = 0; cmd_valid = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ready_linkdown", 80'(cmd_ready), 80'(0));
      step();
    end
    linkup = 1;
    run(0, 0, 48'h1111_2222_3333, 16'd9, 3, 8'h41);
    run(5, 0, 48'h4444_5555_6666, 16'd2, 4, 8'h00);
    run(0, 1, 48'h7777_8888_9999, 16'd7, 7, 8'h58);
    run(0, 0, 48'h0123_4567_89AB, 16'd1, TMO - 1, 8'h40);
    run(3, 1, 48'hCDEF_0123_4567, 16'd5, TMO - 1, 8'h00);
    run(6, 0, 48'h0F0F_F0F0_0F0F, 16'd4, 3, 8'h50);
    run(4, 1, 48'hAAAA_5555_AAAA, 16'd6, 10, 8'h50);
    run(7, 0, 48'h5555_AAAA_5555, 16'd6, 1, 8'h50);
    run(2, 0, 48'h1357_9BDF_2468, 16'd1, 6, 8'h00);
    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 7);
      d = (mode == 2) ? $urandom_range(0, 6) : $urandom_range(0, TMO - 1);
      run(mode, 1'($urandom), {16'($urandom), 32'($urandom)}, ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom),
          d, 8'($urandom));
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
